// File: rtl/dmu_sii_inbound_chk.sv
// dmu_sii_inbound_chk
//   Protocol checker for the DMU-to-SII inbound request interface, running
//   in the iol2clk domain. Decodes request headers, walks the payload beats
//   with a small FSM, counts accepted requests per class, tracks outstanding
//   DMA-write credits against write acks, checks per-group data parity and
//   keeps a sticky error status.
//
// Handshake: dmu_sii_hdr_vld qualifies a header cycle. There is no
//   back-pressure. The payload beats of a request are implied: they occupy
//   the cycles immediately after the header, one beat per cycle, and carry
//   hdr_vld=0. sii_dmu_wrack_vld is a single-cycle strobe that returns one
//   write credit.
//
// Ports:
//   iol2clk, rst_l           clock, asynchronous active-low reset
//   enable                   1 = check and count, 0 = FSM forced to IDLE
//   dmu_sii_*                header/payload request interface (inputs)
//   sii_dmu_wrack_vld        write ack, returns one credit
//   err_clr                  clears err_status on the next edge
//   rd/wr/intr/pio_cnt       accepted-header counters per class
//   cred_out                 outstanding DMA writes
//   busy                     FSM is in a payload state
//   err_pulse                an error was detected in the previous cycle
//   err_status               sticky {underflow, overflow, illegal enc,
//                            header during payload, parity}
//   fsm_state                current FSM state, for debug visibility
module dmu_sii_inbound_chk #(
  parameter int DATA_W     = 128,
  parameter int PAR_GRP    = 16,
  parameter int PAR_ODD    = 0,
  parameter int WR_BEATS   = 4,
  parameter int MD_BEATS   = 1,
  parameter int WR_CREDITS = 16,
  parameter int CNT_W      = 16,
  localparam int PAR_W     = DATA_W / PAR_GRP
) (
  input  logic              iol2clk,
  input  logic              rst_l,
  input  logic              enable,
  input  logic              dmu_sii_hdr_vld,
  input  logic              dmu_sii_datareq,
  input  logic              dmu_sii_datareq16,
  input  logic              dmu_sii_reqbypass,
  input  logic [DATA_W-1:0] dmu_sii_data,
  input  logic [PAR_W-1:0]  dmu_sii_parity,
  input  logic              sii_dmu_wrack_vld,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  intr_cnt,
  output logic [CNT_W-1:0]  pio_cnt,
  output logic [7:0]        cred_out,
  output logic              busy,
  output logic              err_pulse,
  output logic [4:0]        err_status,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_PL = 2'd1,
    MD_PL = 2'd2
  } state_t;

  localparam logic       ODD      = (PAR_ODD != 0);
  localparam logic [7:0] CRED_MAX = 8'(WR_CREDITS);

  state_t     state_q, state_nxt;
  logic [3:0] beat_q, beat_nxt;
  logic [7:0] cred_nxt;

  logic hdr_idle, is_rd, is_wr, is_md, is_ill, hdr_in_pl;
  logic par_err, cred_ovf, cred_unf;
  logic [PAR_W-1:0] par_calc;
  logic [4:0] err_det;

  // Headers are only decoded while idle; a header seen during a payload
  // state is a protocol error and is otherwise ignored.
  assign hdr_idle  = enable && dmu_sii_hdr_vld && (state_q == IDLE);
  assign is_rd     = hdr_idle && !dmu_sii_datareq && !dmu_sii_datareq16;
  assign is_wr     = hdr_idle &&  dmu_sii_datareq && !dmu_sii_datareq16;
  assign is_md     = hdr_idle &&  dmu_sii_datareq &&  dmu_sii_datareq16;
  assign is_ill    = hdr_idle && !dmu_sii_datareq &&  dmu_sii_datareq16;
  assign hdr_in_pl = enable && dmu_sii_hdr_vld && (state_q != IDLE);

  always_comb begin
    par_calc = '0;
    for (int g = 0; g < PAR_W; g++) begin
      par_calc[g] = (^dmu_sii_data[g*PAR_GRP +: PAR_GRP]) ^ ODD;
    end
  end

  // Parity is meaningful only on header and payload cycles.
  assign par_err = enable && (dmu_sii_hdr_vld || (state_q != IDLE)) &&
                   (par_calc != dmu_sii_parity);

  always_comb begin
    state_nxt = state_q;
    beat_nxt  = beat_q;
    case (state_q)
      IDLE: begin
        if (is_wr) begin
          state_nxt = WR_PL;
          beat_nxt  = 4'(WR_BEATS - 1);
        end else if (is_md) begin
          state_nxt = MD_PL;
          beat_nxt  = 4'(MD_BEATS - 1);
        end
      end
      WR_PL, MD_PL: begin
        if (beat_q == 4'd0) begin
          state_nxt = IDLE;
        end else begin
          beat_nxt = beat_q - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!enable) begin
      state_nxt = IDLE;
      beat_nxt  = 4'd0;
    end
  end

  // A write header and an ack in the same cycle cancel out, so neither
  // overflow nor underflow can be flagged in that case. Acks still return
  // credits while checking is disabled; only the error is suppressed.
  always_comb begin
    cred_nxt = cred_out;
    cred_ovf = 1'b0;
    cred_unf = 1'b0;
    if (is_wr && !sii_dmu_wrack_vld) begin
      if (cred_out == CRED_MAX) cred_ovf = 1'b1;
      else                      cred_nxt = cred_out + 8'd1;
    end else if (!is_wr && sii_dmu_wrack_vld) begin
      if (cred_out == 8'd0) cred_unf = enable;
      else                  cred_nxt = cred_out - 8'd1;
    end
  end

  assign err_det = {cred_unf, cred_ovf, is_ill, hdr_in_pl, par_err};

  always_ff @(posedge iol2clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q    <= IDLE;
      beat_q     <= 4'd0;
      rd_cnt     <= '0;
      wr_cnt     <= '0;
      intr_cnt   <= '0;
      pio_cnt    <= '0;
      cred_out   <= 8'd0;
      err_pulse  <= 1'b0;
      err_status <= 5'd0;
    end else begin
      state_q   <= state_nxt;
      beat_q    <= beat_nxt;
      cred_out  <= cred_nxt;
      err_pulse <= |err_det;
      if (is_rd) rd_cnt <= rd_cnt + CNT_W'(1);
      if (is_wr) wr_cnt <= wr_cnt + CNT_W'(1);
      if (is_md && !dmu_sii_reqbypass) intr_cnt <= intr_cnt + CNT_W'(1);
      if (is_md &&  dmu_sii_reqbypass) pio_cnt  <= pio_cnt + CNT_W'(1);
      // Clear wins over any error detected in the same cycle.
      if (err_clr) err_status <= 5'd0;
      else         err_status <= err_status | err_det;
    end
  end

  assign busy      = (state_q != IDLE);
  assign fsm_state = state_q;

endmodule

// File: tb/tb_dmu_sii_inbound_chk.sv
module tb_dmu_sii_inbound_chk;

  localparam int DATA_W = 128;
  localparam int PAR_W  = 8;
  localparam int OUT_W  = 16*4 + 8 + 1 + 1 + 5;

  // clock / reset
  logic iol2clk = 1'b0;
  logic rst_l   = 1'b0;
  always #5 iol2clk = ~iol2clk;

  logic              enable;
  logic              hdr_vld, datareq, datareq16, reqbypass;
  logic [DATA_W-1:0] data;
  logic [PAR_W-1:0]  parity;
  logic              wrack, err_clr;
  logic [15:0]       rd_cnt, wr_cnt, intr_cnt, pio_cnt;
  logic [7:0]        cred_out;
  logic              busy, err_pulse;
  logic [4:0]        err_status;
  logic [1:0]        fsm_state;

  dmu_sii_inbound_chk #(.WR_CREDITS(2)) dut (
    .iol2clk           (iol2clk),
    .rst_l             (rst_l),
    .enable            (enable),
    .dmu_sii_hdr_vld   (hdr_vld),
    .dmu_sii_datareq   (datareq),
    .dmu_sii_datareq16 (datareq16),
    .dmu_sii_reqbypass (reqbypass),
    .dmu_sii_data      (data),
    .dmu_sii_parity    (parity),
    .sii_dmu_wrack_vld (wrack),
    .err_clr           (err_clr),
    .rd_cnt            (rd_cnt),
    .wr_cnt            (wr_cnt),
    .intr_cnt          (intr_cnt),
    .pio_cnt           (pio_cnt),
    .cred_out          (cred_out),
    .busy              (busy),
    .err_pulse         (err_pulse),
    .err_status        (err_status),
    .fsm_state         (fsm_state)
  );

  typedef struct {
    string      name;
    logic       en, h, d, d16, by, wk, clr, flip;
    logic [15:0] rd, wr, in_, pi;
    logic [7:0] cr;
    logic       b, ep;
    logic [4:0] es;
  } vec_t;

  vec_t vecs[$];

  // scoreboard
  logic [OUT_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [OUT_W-1:0] pack(
      input logic [15:0] rd, wr, in_, pi, input logic [7:0] cr,
      input logic b, ep, input logic [4:0] es);
    return {rd, wr, in_, pi, cr, b, ep, es};
  endfunction

  // Even parity per 16-bit group.
  function automatic logic [PAR_W-1:0] gen_par(input logic [DATA_W-1:0] dv);
    logic [PAR_W-1:0] p;
    for (int g = 0; g < PAR_W; g++) p[g] = ^dv[g*16 +: 16];
    return p;
  endfunction

  task automatic check(input string name);
    logic [OUT_W-1:0] exp_v, act_v;
    exp_v = exp_q.pop_front();
    act_v = pack(rd_cnt, wr_cnt, intr_cnt, pio_cnt, cred_out, busy,
                 err_pulse, err_status);
    n_checks++;
    if (act_v === exp_v) n_pass++;
    else $display("FAIL %s: got {rd,wr,intr,pio,cred,busy,pulse,status}=%h expected %h",
                  name, act_v, exp_v);
  endtask

  task automatic add(input string n, input int en, h, d, d16, by, wk, clr, flip,
                     input int rd, wr, in_, pi, cr, b, ep, es);
    vec_t v;
    v.name = n;
    v.en = en[0]; v.h = h[0]; v.d = d[0]; v.d16 = d16[0]; v.by = by[0];
    v.wk = wk[0]; v.clr = clr[0]; v.flip = flip[0];
    v.rd = 16'(rd); v.wr = 16'(wr); v.in_ = 16'(in_); v.pi = 16'(pi);
    v.cr = 8'(cr); v.b = b[0]; v.ep = ep[0]; v.es = 5'(es);
    vecs.push_back(v);
  endtask

  // Plain payload beats: busy stays high except after the last beat.
  task automatic add_beats(input string n, input int cnt,
                           input int rd, wr, in_, pi, cr, es);
    for (int i = 0; i < cnt; i++)
      add($sformatf("%s_b%0d", n, i + 1), 1, 0, 0, 0, 0, 0, 0, 0,
          rd, wr, in_, pi, cr, (i == cnt - 1) ? 0 : 1, 0, es);
  endtask

  // driver
  task automatic drive(input vec_t v);
    logic [DATA_W-1:0] dv;
    enable    = v.en;
    hdr_vld   = v.h;
    datareq   = v.d;
    datareq16 = v.d16;
    reqbypass = v.by;
    wrack     = v.wk;
    err_clr   = v.clr;
    dv = {$urandom, $urandom, $urandom, $urandom};
    parity = gen_par(dv);
    if (v.flip) dv[17] = ~dv[17];
    data = dv;
    exp_q.push_back(pack(v.rd, v.wr, v.in_, v.pi, v.cr, v.b, v.ep, v.es));
  endtask

  task automatic apply(input vec_t v);
    @(negedge iol2clk);
    drive(v);
    @(posedge iol2clk);
    #1;
    check(v.name);
  endtask

  initial begin
    vec_t v;
    enable = 1'b0; hdr_vld = 1'b0; datareq = 1'b0; datareq16 = 1'b0;
    reqbypass = 1'b0; wrack = 1'b0; err_clr = 1'b0;
    data = '0; parity = '0;

    //        name          en h d d16 by wk clr fl  rd wr in pi cr  b ep es
    add("rd1",          1, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0,  0, 0, 0);
    add("rd2",          1, 1, 0, 0, 0, 0, 0, 0,  2, 0, 0, 0, 0,  0, 0, 0);
    add("rd3",          1, 1, 0, 0, 0, 0, 0, 0,  3, 0, 0, 0, 0,  0, 0, 0);
    add("wr1_hdr",      1, 1, 1, 0, 0, 0, 0, 0,  3, 1, 0, 0, 1,  1, 0, 0);
    add_beats("wr1", 4, 3, 1, 0, 0, 1, 0);
    add("md_hdr",       1, 1, 1, 1, 0, 0, 0, 0,  3, 1, 1, 0, 1,  1, 0, 0);
    add_beats("md", 1, 3, 1, 1, 0, 1, 0);
    add("wr2_hdr",      1, 1, 1, 0, 0, 0, 0, 0,  3, 2, 1, 0, 2,  1, 0, 0);
    add("wr2_b1",       1, 0, 0, 0, 0, 0, 0, 0,  3, 2, 1, 0, 2,  1, 0, 0);
    add("wr2_b2_hdr",   1, 1, 0, 0, 0, 0, 0, 0,  3, 2, 1, 0, 2,  1, 1, 2);
    add("wr2_b3",       1, 0, 0, 0, 0, 0, 0, 0,  3, 2, 1, 0, 2,  1, 0, 2);
    add("wr2_b4",       1, 0, 0, 0, 0, 0, 0, 0,  3, 2, 1, 0, 2,  0, 0, 2);
    add("clr1",         1, 0, 0, 0, 0, 0, 1, 0,  3, 2, 1, 0, 2,  0, 0, 0);
    add("ack1",         1, 0, 0, 0, 0, 1, 0, 0,  3, 2, 1, 0, 1,  0, 0, 0);
    add("ack2",         1, 0, 0, 0, 0, 1, 0, 0,  3, 2, 1, 0, 0,  0, 0, 0);
    add("wr3_hdr",      1, 1, 1, 0, 0, 0, 0, 0,  3, 3, 1, 0, 1,  1, 0, 0);
    add_beats("wr3", 4, 3, 3, 1, 0, 1, 0);
    add("wr4_hdr",      1, 1, 1, 0, 0, 0, 0, 0,  3, 4, 1, 0, 2,  1, 0, 0);
    add_beats("wr4", 4, 3, 4, 1, 0, 2, 0);
    add("wr5_ovf",      1, 1, 1, 0, 0, 0, 0, 0,  3, 5, 1, 0, 2,  1, 1, 8);
    add_beats("wr5", 4, 3, 5, 1, 0, 2, 8);
    add("wr6_hdr_ack",  1, 1, 1, 0, 0, 1, 0, 0,  3, 6, 1, 0, 2,  1, 0, 8);
    add_beats("wr6", 4, 3, 6, 1, 0, 2, 8);
    add("ack3",         1, 0, 0, 0, 0, 1, 0, 0,  3, 6, 1, 0, 1,  0, 0, 8);
    add("ack4",         1, 0, 0, 0, 0, 1, 0, 0,  3, 6, 1, 0, 0,  0, 0, 8);
    add("ack_unf",      1, 0, 0, 0, 0, 1, 0, 0,  3, 6, 1, 0, 0,  0, 1, 24);
    add("idle1",        1, 0, 0, 0, 0, 0, 0, 0,  3, 6, 1, 0, 0,  0, 0, 24);
    add("clr2",         1, 0, 0, 0, 0, 0, 1, 0,  3, 6, 1, 0, 0,  0, 0, 0);
    add("pio_hdr",      1, 1, 1, 1, 1, 0, 0, 0,  3, 6, 1, 1, 0,  1, 0, 0);
    add("pio_b1_par",   1, 0, 0, 0, 0, 0, 0, 1,  3, 6, 1, 1, 0,  0, 1, 1);
    add("clr3",         1, 0, 0, 0, 0, 0, 1, 0,  3, 6, 1, 1, 0,  0, 0, 0);
    add("idle_badpar",  1, 0, 0, 0, 0, 0, 0, 1,  3, 6, 1, 1, 0,  0, 0, 0);
    add("ill_hdr",      1, 1, 0, 1, 0, 0, 0, 0,  3, 6, 1, 1, 0,  0, 1, 4);
    add("ill_with_clr", 1, 1, 0, 1, 0, 0, 1, 0,  3, 6, 1, 1, 0,  0, 1, 0);
    add("idle2",        1, 0, 0, 0, 0, 0, 0, 0,  3, 6, 1, 1, 0,  0, 0, 0);
    add("rd_badpar",    1, 1, 0, 0, 0, 0, 0, 1,  4, 6, 1, 1, 0,  0, 1, 1);
    add("clr4",         1, 0, 0, 0, 0, 0, 1, 0,  4, 6, 1, 1, 0,  0, 0, 0);
    add("wr7_hdr",      1, 1, 1, 0, 0, 0, 0, 0,  4, 7, 1, 1, 1,  1, 0, 0);
    add("wr7_b1",       1, 0, 0, 0, 0, 0, 0, 0,  4, 7, 1, 1, 1,  1, 0, 0);
    add("dis_ack",      0, 0, 0, 0, 0, 1, 0, 0,  4, 7, 1, 1, 0,  0, 0, 0);
    add("dis_rd",       0, 1, 0, 0, 0, 0, 0, 0,  4, 7, 1, 1, 0,  0, 0, 0);
    add("dis_ill_par",  0, 1, 0, 1, 0, 0, 0, 1,  4, 7, 1, 1, 0,  0, 0, 0);
    add("en_rd",        1, 1, 0, 0, 0, 0, 0, 0,  5, 7, 1, 1, 0,  0, 0, 0);
    add("wr8_hdr",      1, 1, 1, 0, 0, 0, 0, 0,  5, 8, 1, 1, 1,  1, 0, 0);
    add("wr8_b1",       1, 0, 0, 0, 0, 0, 0, 0,  5, 8, 1, 1, 1,  1, 0, 0);

    // reset state, checked while reset is held
    #1;
    exp_q.push_back('0);
    check("reset_state");
    repeat (2) @(posedge iol2clk);
    @(negedge iol2clk);
    rst_l = 1'b1;

    foreach (vecs[i]) apply(vecs[i]);

    // asynchronous reset on write beat 2: outputs clear without a clock edge
    @(negedge iol2clk);
    hdr_vld = 1'b0;
    rst_l   = 1'b0;
    #1;
    exp_q.push_back('0);
    check("rst_mid_payload");
    @(posedge iol2clk);
    #1;
    exp_q.push_back('0);
    check("rst_held");

    // first header accepted at the first edge after release
    @(negedge iol2clk);
    rst_l = 1'b1;
    v = vecs[0];
    v.name = "rd_after_rst";
    drive(v);
    @(posedge iol2clk);
    #1;
    check(v.name);

    @(negedge iol2clk);
    hdr_vld = 1'b0;
    repeat (2) @(posedge iol2clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
